serial_frame_arbiter: RTL and testbench
=======================================

Name: serial_frame_arbiter

Overview:
Shares one serial-to-parallel deserializer among NUM_SRC serial requesters. Round-robin arbitration picks one requester, which is granted the deserializer for exactly one frame. The block sequences the bit counter and shift register, then presents the parallel frame with its source index on a valid/ready handshake. It sits between the serial input pins and the downstream frame consumer.

Parameters:
NUM_SRC, 4, number of serial requesters (2..8)
FRAME_W, 8, data bits per frame
SRC_W, $clog2(NUM_SRC), width of the source index (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  NUM_SRC  per-source frame request; held high for the whole frame
ser_in  input  NUM_SRC  per-source serial data bit
grant  output  NUM_SRC  one-hot grant; granted source drives one bit per cycle
busy  output  1  high in every state except IDLE
frame_out  output  FRAME_W  assembled frame
frame_src  output  SRC_W  index of the source that sent frame_out
frame_valid  output  1  frame_out and frame_src are valid
frame_ready  input  1  consumer accepts the frame
frame_err  output  1  parity error flag; qualified by frame_valid

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, busy=0, frame_valid=0, frame_err=0, frame_out=0, frame_src=0, rr pointer=0, bit counter=0. Reset mid-frame discards the partial frame immediately.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: if any req bit is set, select the first set bit searching from rr pointer upward, wrapping modulo NUM_SRC.
  - Register the selection into grant and frame_src; clear the bit counter; go to SHIFT.
  - If no req is set, stay in IDLE.
- SHIFT: grant is held one-hot. Each cycle, frame_out <= {frame_out[FRAME_W-2:0], ser_in[frame_src]}, so the first bit lands in the MSB. The bit counter increments.
  - After the FRAME_W-th sample, clear grant and go to HOLD with frame_valid=1.
  - Latency: req seen in IDLE at cycle k → grant high in cycles k+1..k+FRAME_W → frame_valid high from cycle k+FRAME_W+1.
- Abort: if req[frame_src] is low in any SHIFT cycle, do not sample that cycle's bit. Clear grant, return to IDLE, set rr pointer = frame_src+1 (mod NUM_SRC), never assert frame_valid.
- HOLD: frame_out, frame_src and frame_err are stable while frame_valid=1 and frame_ready=0.
  - On frame_valid & frame_ready: clear frame_valid, set rr pointer = frame_src+1 (mod NUM_SRC), go to IDLE.
  - Minimum frame period is FRAME_W+2 cycles.
- Requests are ignored outside IDLE; req changes on other sources never affect the active grant.
- Wrap-around: rr pointer NUM_SRC-1 → 0.
- Simultaneous requests: the lowest index at or above the pointer wins, so each source is served at most once per NUM_SRC grants while others wait.
- frame_ready asserted while frame_valid=0 has no effect.

Optional Feature:
Macro FRAME_PARITY_EN.
- Defined: SHIFT samples FRAME_W+1 bits. The final bit is an even-parity bit and is not stored in frame_out. In HOLD, frame_err = XOR of all FRAME_W data bits and the parity bit. The frame is still delivered when frame_err=1. Latency grows by one cycle.
- Undefined: SHIFT samples exactly FRAME_W bits and frame_err is tied to 0.

Decomposition:
- Package serial_frame_pkg: state enum (IDLE, SHIFT, HOLD), default FRAME_W and NUM_SRC constants, and a round-robin next-index function.
- One natural sub-module, frame_deser: FRAME_W shift register plus bit counter with clear, shift_en and done outputs. The arbiter FSM, pointer and grant logic live in the top.

Test Plan:
- Reset, then req=4'b0001 with src0 sending 8'hA5 MSB first → grant=0001 for 8 cycles; frame_valid at cycle 10 after req; frame_out=8'hA5, frame_src=0.
- req=4'b1111 held, frame_ready=1 → grants in order src0, src1, src2, src3, src0; each frame period is 10 cycles.
- frame_ready=0 for 5 cycles after valid → frame_out and frame_src stable, grant=0; with ready=1, IDLE next cycle and src1 is granted.
- req[2] dropped after 3 bits → no frame_valid; next grant goes to src3 if it is requesting.
- rst pulsed low in the 4th SHIFT cycle → all outputs 0 immediately; first grant after release goes to src0.
- FRAME_PARITY_EN: data 8'h03 with parity 1 → frame_err=1; with parity 0 → frame_err=0; frame_valid at cycle 11.

Source files
------------

// File: rtl/serial_frame_arbiter_pkg.sv
// Shared types and helpers for the serial frame arbiter: FSM states, default sizes
// and the round-robin source picker.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_FRAME_W = 8;
    localparam int MAX_SRC     = 8;

    // First set request at or above ptr, wrapping modulo n; only meaningful when |req.
    function automatic logic [2:0] rr_next(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [2:0] sel;
        int         idx;
        sel = ptr;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (req[idx]) sel = idx[2:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/serial_frame_arbiter_if.sv
// Request/serial/frame bundle between the serial requesters, the arbiter and the
// frame consumer. The arbiter side uses modport master.
interface serial_frame_arbiter_if
    import serial_frame_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int FRAME_W = DEF_FRAME_W
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] ser_in;
    logic [NUM_SRC-1:0] grant;
    logic               busy;
    logic [FRAME_W-1:0] frame_out;
    logic [SRC_W-1:0]   frame_src;
    logic               frame_valid;
    logic               frame_ready;
    logic               frame_err;

    modport master (
        input  req, ser_in, frame_ready,
        output grant, busy, frame_out, frame_src, frame_valid, frame_err
    );

    modport slave (
        output req, ser_in, frame_ready,
        input  grant, busy, frame_out, frame_src, frame_valid, frame_err
    );

endinterface

// File: rtl/serial_frame_arbiter_deser.sv
// Shift register and bit counter shared by all requesters. With FRAME_PARITY_EN the
// last sampled bit is an even-parity bit checked into err_o instead of being stored.
module frame_deser #(
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_en_i,
    input  logic               bit_i,
    output logic               done_o,
    output logic [FRAME_W-1:0] data_o,
    output logic               err_o
);
`ifdef FRAME_PARITY_EN
    localparam int NBITS = FRAME_W + 1;
`else
    localparam int NBITS = FRAME_W;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] data_q, data_d;

    // done_o flags that the sample taken this cycle is the last one of the frame.
    assign done_o = (cnt_q == CNT_W'(NBITS - 1));
    assign data_o = data_q;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_en_i) begin
            cnt_d = cnt_q + 1'b1;
`ifdef FRAME_PARITY_EN
            if (!done_o) data_d = {data_q[FRAME_W-2:0], bit_i};
`else
            data_d = {data_q[FRAME_W-2:0], bit_i};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

`ifdef FRAME_PARITY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clear_i)                    err_d = 1'b0;
        else if (shift_en_i && done_o)  err_d = (^data_q) ^ bit_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter sharing one deserializer among NUM_SRC serial requesters; each
// grant covers one frame. Optional parity check enabled by FRAME_PARITY_EN.
module serial_frame_arbiter
    import serial_frame_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_frame_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(NUM_SRC);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;

    logic               clear, shift_en, done;
    logic [MAX_SRC-1:0] req_pad;
    logic [2:0]         sel;
    logic [SRC_W-1:0]   src_inc;

    assign src_inc = (src_q == SRC_W'(NUM_SRC - 1)) ? '0 : src_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        src_d    = src_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        clear    = 1'b0;
        shift_en = 1'b0;
        req_pad  = '0;
        req_pad[NUM_SRC-1:0] = bus.req;
        sel      = rr_next(req_pad, 3'(ptr_q), NUM_SRC);

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    src_d = sel[SRC_W-1:0];
                    for (int i = 0; i < NUM_SRC; i++) grant_d[i] = (int'(sel) == i);
                    clear   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A dropped request abandons the frame without sampling this cycle's bit.
                if (!bus.req[src_q]) begin
                    grant_d = '0;
                    ptr_d   = src_inc;
                    state_d = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (done) begin
                        grant_d = '0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = src_inc;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    frame_deser #(.FRAME_W(FRAME_W)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .shift_en_i (shift_en),
        .bit_i      (bus.ser_in[src_q]),
        .done_o     (done),
        .data_o     (bus.frame_out),
        .err_o      (bus.frame_err)
    );

    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_src   = src_q;
    assign bus.frame_valid = valid_q;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Randomized self-checking bench for serial_frame_arbiter against a transaction-level
// round-robin model; covers the FRAME_PARITY_EN build when that macro is defined.
module tb_serial_frame_arbiter;
    import serial_frame_pkg::*;

`ifdef FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 8 + PAR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_ptr = 0;

    serial_frame_arbiter_if #(.NUM_SRC(4), .FRAME_W(8)) bus ();

    serial_frame_arbiter #(.NUM_SRC(4), .FRAME_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    // One complete frame starting in an IDLE cycle; returns the served source and valid cycle.
    task automatic run_frame(input logic [3:0] r, input logic [7:0] data, input logic pbit,
                             input int delay, output int src, output int vcyc);
        logic [3:0] g;
        logic       eerr;
        src  = pick(r, exp_ptr);
        g    = 4'(1 << src);
        eerr = (PAR == 1) ? ((^data) ^ pbit) : 1'b0;
        bus.req = r;
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            total++;
            if (bus.grant !== g || bus.frame_valid !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL shift%0d: grant=%b valid=%b busy=%b, want grant=%b valid=0 busy=1",
                         i, bus.grant, bus.frame_valid, bus.busy, g);
            end
            bus.req         = 4'($urandom) | g;
            bus.ser_in      = 4'($urandom);
            bus.ser_in[src] = (i < 8) ? data[7 - i] : pbit;
            bus.frame_ready = 1'($urandom);
            @(negedge clk);
        end
        vcyc = cyc;
        bus.frame_ready = 1'b0;
        bus.req = 4'($urandom);
        for (int d = 0; d <= delay; d++) begin
            total++;
            if (bus.frame_valid !== 1'b1 || bus.grant !== 4'b0 || bus.frame_out !== data ||
                bus.frame_src !== 2'(src) || bus.frame_err !== eerr) begin
                bad++;
                $display("FAIL hold%0d: valid=%b grant=%b out=%h src=%0d err=%b, want 1 0000 %h %0d %b",
                         d, bus.frame_valid, bus.grant, bus.frame_out, bus.frame_src,
                         bus.frame_err, data, src, eerr);
            end
            if (d == delay) bus.frame_ready = 1'b1;
            @(negedge clk);
        end
        bus.frame_ready = 1'b0;
        bus.req = 4'b0;
        total++;
        if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL release: valid=%b busy=%b, want 0 0", bus.frame_valid, bus.busy);
        end
        exp_ptr = (src + 1) % 4;
    endtask

    task automatic test_reset();
        bus.req = 4'b0; bus.ser_in = 4'b0; bus.frame_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 ||
                bus.frame_err !== 1'b0 || bus.frame_out !== 8'h00 || bus.frame_src !== 2'd0) begin
                bad++;
                $display("FAIL reset: grant=%b busy=%b valid=%b err=%b out=%h src=%0d, want all 0",
                         bus.grant, bus.busy, bus.frame_valid, bus.frame_err, bus.frame_out,
                         bus.frame_src);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int src, vc, prev;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame(4'hF, 8'($urandom), 1'($urandom), 0, src, vc);
            total++;
            if (src != (i % 4) || (i > 0 && vc - prev != NB + 2)) begin
                bad++;
                $display("FAIL b2b%0d: src=%0d period=%0d, want src=%0d period=%0d",
                         i, src, vc - prev, i % 4, NB + 2);
            end
            prev = vc;
        end
    endtask

    task automatic test_single();
        int src, vc;
        run_frame(4'b0001, 8'hA5, 1'b0, 0, src, vc);
    endtask

    task automatic test_stall();
        int s0, s1, vc;
        run_frame(4'b0011, 8'($urandom), 1'($urandom), 5, s0, vc);
        run_frame(4'b0011, 8'($urandom), 1'($urandom), 0, s1, vc);
        total++;
        if (s0 == s1) begin
            bad++;
            $display("FAIL stall_rr: second src=%0d, want other than %0d", s1, s0);
        end
    endtask

    task automatic test_abort();
        int src, vc;
        run_frame(4'b0010, 8'($urandom), 1'($urandom), 0, src, vc);
        bus.req = 4'b1100;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.ser_in = 4'($urandom);
            @(negedge clk);
        end
        bus.req = 4'b1000;
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort: grant=%b busy=%b valid=%b, want 0 0 0",
                     bus.grant, bus.busy, bus.frame_valid);
        end
        exp_ptr = 3;
        run_frame(4'b1000, 8'($urandom), 1'($urandom), 0, src, vc);
        total++;
        if (src != 3) begin
            bad++;
            $display("FAIL abort_next: src=%0d, want 3", src);
        end
    endtask

    task automatic test_reset_mid();
        int src, vc;
        bus.req = 4'b0100;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.ser_in = 4'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 ||
            bus.frame_out !== 8'h00 || bus.frame_src !== 2'd0 || bus.frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: grant=%b busy=%b valid=%b out=%h src=%0d err=%b, want all 0",
                     bus.grant, bus.busy, bus.frame_valid, bus.frame_out, bus.frame_src,
                     bus.frame_err);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b0;
        exp_ptr = 0;
        @(negedge clk);
        run_frame(4'hF, 8'($urandom), 1'($urandom), 0, src, vc);
        total++;
        if (src != 0) begin
            bad++;
            $display("FAIL reset_rr: src=%0d, want 0", src);
        end
    endtask

    task automatic test_parity();
        int src, vc;
        run_frame(4'b0001, 8'h03, 1'b1, 0, src, vc);
        run_frame(4'b0001, 8'h03, 1'b0, 0, src, vc);
    endtask

    task automatic test_random();
        int src, vc;
        logic [3:0] r;
        for (int n = 0; n < 25; n++) begin
            r = 4'($urandom_range(1, 15));
            run_frame(r, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), src, vc);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_stall();
        test_abort();
        test_reset_mid();
        test_parity();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
